// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES accelerator control path.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_ROUND,
        ST_FINISH,
        ST_DONE
    } ctrl_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int unsigned nr_of(input int unsigned k);
        case (k)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_ctrl_if.sv
// Load strobe in, round-sequencing controls out, between controller and AES core/SPI block.
interface aes_ctrl_if;
    logic       load;
    logic       capture;
    logic       round_en;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       first_round;
    logic       last_round;
    logic       out_we;
    logic       done;
    logic       abort;

    modport master (
        input  load,
        output capture, round_en, round, rcon, first_round, last_round, out_we, done, abort
    );

    modport slave (
        output load,
        input  capture, round_en, round, rcon, first_round, last_round, out_we, done, abort
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for slow control signals entering the clk domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/aes_ctrl.sv
// AES round sequencer: synchronizes load, walks capture/rounds/finish and reports done.
module aes_ctrl
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    aes_ctrl_if.master bus
);
    localparam logic [3:0] NR = 4'(nr_of(K));

    logic        load_s;
    logic        load_prev_q;
    logic        load_rise;
    logic        load_fall;
    ctrl_state_t state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        capture_q, capture_d;
    logic        round_en_q, round_en_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        out_we_q, out_we_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    sync2 #(.WIDTH(1)) u_load_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (bus.load),
        .q_o  (load_s)
    );

    assign load_rise = load_s & ~load_prev_q;
    assign load_fall = ~load_s & load_prev_q;

    // Outputs are computed for the next state so every one leaves a flop.
    always_comb begin
        state_d    = state_q;
        round_d    = '0;
        rcon_d     = RCON_INIT;
        capture_d  = 1'b0;
        round_en_d = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        out_we_d   = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_fall) begin
                    state_d   = ST_CAPTURE;
                    capture_d = 1'b1;
                    first_d   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (load_rise) begin
                    state_d = ST_LOAD;
                    abort_d = 1'b1;
                end else begin
                    state_d    = ST_ROUND;
                    round_en_d = 1'b1;
                    round_d    = 4'd1;
                    last_d     = (NR == 4'd1);
                end
            end
            ST_ROUND: begin
                if (load_rise) begin
                    state_d = ST_LOAD;
                    abort_d = 1'b1;
                end else if (round_q == NR) begin
                    state_d  = ST_FINISH;
                    out_we_d = 1'b1;
                end else begin
                    round_en_d = 1'b1;
                    round_d    = round_q + 4'd1;
                    rcon_d     = xtime(rcon_q);
                    last_d     = (round_q + 4'd1 == NR);
                end
            end
            ST_FINISH: begin
                if (load_rise) begin
                    state_d = ST_LOAD;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load_rise) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_prev_q <= 1'b0;
            round_q     <= '0;
            rcon_q      <= RCON_INIT;
            capture_q   <= 1'b0;
            round_en_q  <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            out_we_q    <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_prev_q <= load_s;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            capture_q   <= capture_d;
            round_en_q  <= round_en_d;
            first_q     <= first_d;
            last_q      <= last_d;
            out_we_q    <= out_we_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.capture     = capture_q;
    assign bus.round_en    = round_en_q;
    assign bus.round       = round_q;
    assign bus.rcon        = rcon_q;
    assign bus.first_round = first_q;
    assign bus.last_round  = last_q;
    assign bus.out_we      = out_we_q;
    assign bus.done        = done_q;
    assign bus.abort       = abort_q;
endmodule

// File: tb/tb_aes_ctrl.sv
// Scoreboard bench for aes_ctrl: K=128 and K=256 instances share clock, reset and load.
module tb_aes_ctrl;
    import aes_pkg::*;

    typedef struct packed {
        int unsigned cyc;
        logic [6:0]  flg;   // {capture, round_en, first, last, out_we, abort, done}
        logic [3:0]  rnd;
        logic [7:0]  rc;
    } evt_t;

    localparam logic [6:0] F_CAP   = 7'b1000000;
    localparam logic [6:0] F_RE    = 7'b0100000;
    localparam logic [6:0] F_FIRST = 7'b0010000;
    localparam logic [6:0] F_LAST  = 7'b0001000;
    localparam logic [6:0] F_WE    = 7'b0000100;
    localparam logic [6:0] F_AB    = 7'b0000010;
    localparam logic [6:0] F_DONE  = 7'b0000001;

    logic [7:0] rcon_tbl [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    int unsigned cyc   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        dprev0 = 1'b0;
    logic        dprev1 = 1'b0;
    evt_t        exp_q [2][$];
    evt_t        obs_q [2][$];

    aes_ctrl_if if0();
    aes_ctrl_if if1();
    assign if0.load = load;
    assign if1.load = load;

    aes_ctrl #(.K(128)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    aes_ctrl #(.K(256)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic evt_t mk(input int unsigned c, input logic [6:0] f,
                                input logic [3:0] r, input logic [7:0] rc);
        evt_t e;
        e.cyc = c;
        e.flg = f;
        e.rnd = r;
        e.rc  = rc;
        return e;
    endfunction

    // Record every cycle with a strobe active or a done transition.
    always @(negedge clk) begin
        if (if0.capture | if0.round_en | if0.out_we | if0.abort | (if0.done != dprev0))
            obs_q[0].push_back(mk(cyc, {if0.capture, if0.round_en, if0.first_round, if0.last_round,
                                        if0.out_we, if0.abort, if0.done}, if0.round, if0.rcon));
        if (if1.capture | if1.round_en | if1.out_we | if1.abort | (if1.done != dprev1))
            obs_q[1].push_back(mk(cyc, {if1.capture, if1.round_en, if1.first_round, if1.last_round,
                                        if1.out_we, if1.abort, if1.done}, if1.round, if1.rcon));
        dprev0 <= if0.done;
        dprev1 <= if1.done;
    end

    function automatic int nr_dut(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    task automatic push_run(input int d, input int unsigned e0);
        int nr;
        nr = nr_dut(d);
        exp_q[d].push_back(mk(e0 + 2, F_CAP | F_FIRST, 4'd0, 8'h01));
        for (int r = 1; r <= nr; r++)
            exp_q[d].push_back(mk(e0 + 2 + r, F_RE | ((r == nr) ? F_LAST : 7'b0), 4'(r), rcon_tbl[r-1]));
        exp_q[d].push_back(mk(e0 + 3 + nr, F_WE, 4'd0, 8'h01));
        exp_q[d].push_back(mk(e0 + 4 + nr, F_DONE, 4'd0, 8'h01));
    endtask

    task automatic drive_load(input logic v, output int unsigned e);
        @(posedge clk);
        #1;
        load = v;
        e = cyc + 1;
    endtask

    task automatic test_reset();
        int unsigned e0;
        logic [18:0] got;
        evt_t e, o;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? {if0.capture, if0.round_en, if0.round, if0.rcon, if0.first_round,
                              if0.last_round, if0.out_we, if0.done, if0.abort}
                           : {if1.capture, if1.round_en, if1.round, if1.rcon, if1.first_round,
                              if1.last_round, if1.out_we, if1.done, if1.abort};
            n_tests++;
            if (got !== {6'b0, 8'h01, 5'b0}) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got %h want %h", k, got, {6'b0, 8'h01, 5'b0});
            end
        end
        n_tests++;
        if (dut0.state_q !== ST_IDLE || dut1.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state got %0d/%0d want %0d", dut0.state_q, dut1.state_q, ST_IDLE);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_load(1'b1, e0);
        repeat (9) @(posedge clk);
        drive_load(1'b0, e0);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].push_back(mk(e0 + 2, F_CAP | F_FIRST, 4'd0, 8'h01));
            for (int r = 1; r <= 5; r++)
                exp_q[d].push_back(mk(e0 + 2 + r, F_RE, 4'(r), rcon_tbl[r-1]));
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? {if0.capture, if0.round_en, if0.round, if0.rcon, if0.first_round,
                              if0.last_round, if0.out_we, if0.done, if0.abort}
                           : {if1.capture, if1.round_en, if1.round, if1.rcon, if1.first_round,
                              if1.last_round, if1.out_we, if1.done, if1.abort};
            n_tests++;
            if (got !== {6'b0, 8'h01, 5'b0}) begin
                n_fail++;
                $display("FAIL midround_reset dut%0d got %h want %h", k, got, {6'b0, 8'h01, 5'b0});
            end
        end
        n_tests++;
        if (dut0.state_q !== ST_IDLE || dut1.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midround_reset_state got %0d/%0d want %0d", dut0.state_q, dut1.state_q, ST_IDLE);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            while (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = '0;
                if (obs_q[d].size() > 0) o = obs_q[d].pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reset_run dut%0d got cyc=%0d f=%b r=%0d rc=%h want cyc=%0d f=%b r=%0d rc=%h",
                             d, o.cyc, o.flg, o.rnd, o.rc, e.cyc, e.flg, e.rnd, e.rc);
                end
            end
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL reset_run dut%0d extra events got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
    endtask

    task automatic test_full_run();
        int unsigned e0;
        evt_t e, o;
        drive_load(1'b1, e0);
        repeat (9) @(posedge clk);
        drive_load(1'b0, e0);
        push_run(0, e0);
        push_run(1, e0);
        repeat (22) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            while (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = '0;
                if (obs_q[d].size() > 0) o = obs_q[d].pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL full_run dut%0d got cyc=%0d f=%b r=%0d rc=%h want cyc=%0d f=%b r=%0d rc=%h",
                             d, o.cyc, o.flg, o.rnd, o.rc, e.cyc, e.flg, e.rnd, e.rc);
                end
            end
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL full_run dut%0d extra events got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
        n_tests++;
        if (if0.done !== 1'b1 || if1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_run_done_held got %b%b want 11", if0.done, if1.done);
        end
    endtask

    task automatic test_glitch_ignore();
        @(posedge clk);
        #2 load = 1'b1;
        #2 load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if (if0.done !== 1'b1 || if1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_done got %b%b want 11", if0.done, if1.done);
        end
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL glitch_events dut%0d got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned r0, e0;
        evt_t e, o;
        drive_load(1'b1, r0);
        for (int d = 0; d < 2; d++) exp_q[d].push_back(mk(r0 + 2, 7'b0, 4'd0, 8'h01));
        repeat (9) @(posedge clk);
        drive_load(1'b0, e0);
        push_run(0, e0);
        push_run(1, e0);
        repeat (22) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            while (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = '0;
                if (obs_q[d].size() > 0) o = obs_q[d].pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d got cyc=%0d f=%b r=%0d rc=%h want cyc=%0d f=%b r=%0d rc=%h",
                             d, o.cyc, o.flg, o.rnd, o.rc, e.cyc, e.flg, e.rnd, e.rc);
                end
            end
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL back_to_back dut%0d extra events got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
    endtask

    task automatic test_abort();
        int unsigned r0, e0;
        evt_t e, o;
        drive_load(1'b1, r0);
        for (int d = 0; d < 2; d++) exp_q[d].push_back(mk(r0 + 2, 7'b0, 4'd0, 8'h01));
        repeat (9) @(posedge clk);
        drive_load(1'b0, e0);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].push_back(mk(e0 + 2, F_CAP | F_FIRST, 4'd0, 8'h01));
            for (int r = 1; r <= 4; r++)
                exp_q[d].push_back(mk(e0 + 2 + r, F_RE, 4'(r), rcon_tbl[r-1]));
            exp_q[d].push_back(mk(e0 + 7, F_AB, 4'd0, 8'h01));
        end
        // Raising load here makes the rise visible to the FSM while round 4 is current.
        repeat (4) @(posedge clk);
        drive_load(1'b1, r0);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (dut0.state_q !== ST_LOAD || dut1.state_q !== ST_LOAD) begin
            n_fail++;
            $display("FAIL abort_state got %0d/%0d want %0d", dut0.state_q, dut1.state_q, ST_LOAD);
        end
        n_tests++;
        if (if0.done !== 1'b0 || if1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done got %b%b want 00", if0.done, if1.done);
        end
        repeat (3) @(posedge clk);
        drive_load(1'b0, e0);
        push_run(0, e0);
        push_run(1, e0);
        repeat (22) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            while (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = '0;
                if (obs_q[d].size() > 0) o = obs_q[d].pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL abort dut%0d got cyc=%0d f=%b r=%0d rc=%h want cyc=%0d f=%b r=%0d rc=%h",
                             d, o.cyc, o.flg, o.rnd, o.rc, e.cyc, e.flg, e.rnd, e.rc);
                end
            end
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL abort dut%0d extra events got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
    endtask

    task automatic test_pulse_idle();
        int unsigned c, e0;
        evt_t e, o;
        @(posedge clk);
        #1 rst_n = 1'b0;
        c = cyc;
        for (int d = 0; d < 2; d++) exp_q[d].push_back(mk(c, 7'b0, 4'd0, 8'h01));
        #1;
        n_tests++;
        if (if0.done !== 1'b0 || if1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_done_drop got %b%b want 00", if0.done, if1.done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_load(1'b1, e0);
        drive_load(1'b0, e0);
        repeat (22) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            // A detected pulse must yield a complete run; otherwise only the reset done-drop is seen.
            if (obs_q[d].size() > 1) push_run(d, e0);
            while (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = '0;
                if (obs_q[d].size() > 0) o = obs_q[d].pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL pulse_idle dut%0d got cyc=%0d f=%b r=%0d rc=%h want cyc=%0d f=%b r=%0d rc=%h",
                             d, o.cyc, o.flg, o.rnd, o.rc, e.cyc, e.flg, e.rnd, e.rc);
                end
            end
            n_tests++;
            if (obs_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL pulse_idle dut%0d extra events got %0d want 0", d, obs_q[d].size());
                obs_q[d].delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_glitch_ignore();
        test_back_to_back();
        test_abort();
        test_pulse_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
